// File: rtl/de_ex_reg.sv
// de_ex_reg: decode-to-execute pipeline register with stall, flush and writeback bypass.
// Ports: clk/rst (sync, active-high); stall/flush; decode fields (*_de, ru1/ru2, ImmExt,
// control bits) in; writeback bus (RuWr_wb, rd_wb, muxData) in; registered *_ex fields,
// valid_ex and a saturating bubble_cnt out.
module de_ex_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             valid_de,
    input  logic [XLEN-1:0]  pc_de,
    input  logic [XLEN-1:0]  ru1,
    input  logic [XLEN-1:0]  ru2,
    input  logic [XLEN-1:0]  ImmExt,
    input  logic [4:0]       rs1_de,
    input  logic [4:0]       rs2_de,
    input  logic [4:0]       rd_de,
    input  logic             AluASrc,
    input  logic             AluBSrc,
    input  logic             RuWr,
    input  logic             DMWr,
    input  logic [1:0]       RUDataWrSrc,
    input  logic [3:0]       AluOp,
    input  logic [4:0]       BrOp,
    input  logic [2:0]       DMCtrl,
    input  logic             RuWr_wb,
    input  logic [4:0]       rd_wb,
    input  logic [XLEN-1:0]  muxData,
    output logic [XLEN-1:0]  pc_ex,
    output logic [XLEN-1:0]  ru1_ex,
    output logic [XLEN-1:0]  ru2_ex,
    output logic [XLEN-1:0]  ImmExt_ex,
    output logic [4:0]       rs1_ex,
    output logic [4:0]       rs2_ex,
    output logic [4:0]       rd_ex,
    output logic             AluASrc_ex,
    output logic             AluBSrc_ex,
    output logic             RuWr_ex,
    output logic             DMWr_ex,
    output logic [1:0]       RUDataWrSrc_ex,
    output logic [3:0]       AluOp_ex,
    output logic [4:0]       BrOp_ex,
    output logic [2:0]       DMCtrl_ex,
    output logic             valid_ex,
    output logic [CNT_W-1:0] bubble_cnt
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ru1;
        logic [XLEN-1:0] ru2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            asrc;
        logic            bsrc;
        logic            ruwr;
        logic            dmwr;
        logic [1:0]      wrsrc;
        logic [3:0]      aluop;
        logic [4:0]      brop;
        logic [2:0]      dmctrl;
    } slot_t;

    slot_t            ex_d, ex_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             wb_hit;
    logic [CNT_W-1:0] cnt_inc;

    // x0 writes never forward
    assign wb_hit  = RuWr_wb && (rd_wb != 5'd0);
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (flush) begin
            ex_d  = '0;
            cnt_d = cnt_inc;
        end else if (stall) begin
            // the held instruction must still see writebacks that land while it waits
            if (ex_q.valid && wb_hit && rd_wb == ex_q.rs1) ex_d.ru1 = muxData;
            if (ex_q.valid && wb_hit && rd_wb == ex_q.rs2) ex_d.ru2 = muxData;
        end else begin
            ex_d = '{valid: valid_de, pc: pc_de,
                     ru1: (wb_hit && rd_wb == rs1_de) ? muxData : ru1,
                     ru2: (wb_hit && rd_wb == rs2_de) ? muxData : ru2,
                     imm: ImmExt, rs1: rs1_de, rs2: rs2_de, rd: rd_de,
                     asrc: AluASrc, bsrc: AluBSrc,
                     ruwr: RuWr && valid_de, dmwr: DMWr && valid_de,
                     wrsrc: RUDataWrSrc, aluop: AluOp,
                     brop: valid_de ? BrOp : 5'd0, dmctrl: DMCtrl};
            cnt_d = valid_de ? cnt_q : cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign valid_ex       = ex_q.valid;
    assign pc_ex          = ex_q.pc;
    assign ru1_ex         = ex_q.ru1;
    assign ru2_ex         = ex_q.ru2;
    assign ImmExt_ex      = ex_q.imm;
    assign rs1_ex         = ex_q.rs1;
    assign rs2_ex         = ex_q.rs2;
    assign rd_ex          = ex_q.rd;
    assign AluASrc_ex     = ex_q.asrc;
    assign AluBSrc_ex     = ex_q.bsrc;
    assign RuWr_ex        = ex_q.ruwr;
    assign DMWr_ex        = ex_q.dmwr;
    assign RUDataWrSrc_ex = ex_q.wrsrc;
    assign AluOp_ex       = ex_q.aluop;
    assign BrOp_ex        = ex_q.brop;
    assign DMCtrl_ex      = ex_q.dmctrl;
    assign bubble_cnt     = cnt_q;
endmodule

// File: tb/tb_de_ex_reg.sv
// tb_de_ex_reg: directed self-checking bench for de_ex_reg (CNT_W=2 to reach saturation).
module tb_de_ex_reg;
    logic        clk = 1'b0;
    logic        rst, stall, flush, valid_de;
    logic [31:0] pc_de, ru1, ru2, ImmExt, muxData;
    logic [4:0]  rs1_de, rs2_de, rd_de, rd_wb, BrOp;
    logic        AluASrc, AluBSrc, RuWr, DMWr, RuWr_wb;
    logic [1:0]  RUDataWrSrc;
    logic [3:0]  AluOp;
    logic [2:0]  DMCtrl;
    logic [31:0] pc_ex, ru1_ex, ru2_ex, ImmExt_ex;
    logic [4:0]  rs1_ex, rs2_ex, rd_ex, BrOp_ex;
    logic        AluASrc_ex, AluBSrc_ex, RuWr_ex, DMWr_ex, valid_ex;
    logic [1:0]  RUDataWrSrc_ex;
    logic [3:0]  AluOp_ex;
    logic [2:0]  DMCtrl_ex;
    logic [1:0]  bubble_cnt;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    de_ex_reg #(.XLEN(32), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_de(valid_de),
        .pc_de(pc_de), .ru1(ru1), .ru2(ru2), .ImmExt(ImmExt),
        .rs1_de(rs1_de), .rs2_de(rs2_de), .rd_de(rd_de),
        .AluASrc(AluASrc), .AluBSrc(AluBSrc), .RuWr(RuWr), .DMWr(DMWr),
        .RUDataWrSrc(RUDataWrSrc), .AluOp(AluOp), .BrOp(BrOp), .DMCtrl(DMCtrl),
        .RuWr_wb(RuWr_wb), .rd_wb(rd_wb), .muxData(muxData),
        .pc_ex(pc_ex), .ru1_ex(ru1_ex), .ru2_ex(ru2_ex), .ImmExt_ex(ImmExt_ex),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
        .AluASrc_ex(AluASrc_ex), .AluBSrc_ex(AluBSrc_ex), .RuWr_ex(RuWr_ex),
        .DMWr_ex(DMWr_ex), .RUDataWrSrc_ex(RUDataWrSrc_ex), .AluOp_ex(AluOp_ex),
        .BrOp_ex(BrOp_ex), .DMCtrl_ex(DMCtrl_ex), .valid_ex(valid_ex),
        .bubble_cnt(bubble_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        {stall, flush, valid_de, AluASrc, AluBSrc, RuWr, DMWr, RuWr_wb} = '0;
        {pc_de, ru1, ru2, ImmExt, muxData} = '0;
        {rs1_de, rs2_de, rd_de, rd_wb, BrOp} = '0;
        {RUDataWrSrc, AluOp, DMCtrl} = '0;
    endtask

    function automatic logic all_zero();
        return ({pc_ex, ru1_ex, ru2_ex, ImmExt_ex, rs1_ex, rs2_ex, rd_ex, AluASrc_ex,
                 AluBSrc_ex, RuWr_ex, DMWr_ex, RUDataWrSrc_ex, AluOp_ex, BrOp_ex,
                 DMCtrl_ex, valid_ex, bubble_cnt} == '0);
    endfunction

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        valid_de = 1'b1; RuWr_wb = 1'b1;
        pc_de = $urandom; ru1 = $urandom; ru2 = $urandom; ImmExt = $urandom; muxData = $urandom;
        rs1_de = 5'($urandom); rs2_de = 5'($urandom); rd_de = 5'($urandom); rd_wb = 5'($urandom);
        BrOp = 5'h1f; AluOp = 4'hf; DMCtrl = 3'h7; RUDataWrSrc = 2'h3;
        {AluASrc, AluBSrc, RuWr, DMWr} = 4'hf;
        step(); step();
        chk("reset_all_zero", all_zero(), 1'b1);
        chk("reset_valid", valid_ex, 1'b0);
        chk("reset_cnt", bubble_cnt, 2'd0);

        rst = 1'b0; clear_in();
        valid_de = 1'b1; ru1 = 32'h11; rs1_de = 5'd3; AluOp = 4'h2; pc_de = 32'h100;
        step();
        chk("load_ru1", ru1_ex, 32'h11);
        chk("load_aluop", AluOp_ex, 4'h2);
        chk("load_valid", valid_ex, 1'b1);
        chk("load_pc", pc_ex, 32'h100);
        chk("load_rs1", rs1_ex, 5'd3);

        rs1_de = 5'd5; rs2_de = 5'd5; ru1 = 32'hAAAA; ru2 = 32'hAAAA;
        RuWr_wb = 1'b1; rd_wb = 5'd5; muxData = 32'h1234;
        step();
        chk("byp_ru1", ru1_ex, 32'h1234);
        chk("byp_ru2", ru2_ex, 32'h1234);
        rd_wb = 5'd0;
        step();
        chk("byp_x0_ru1", ru1_ex, 32'hAAAA);
        chk("byp_x0_ru2", ru2_ex, 32'hAAAA);
        rd_wb = 5'd5; RuWr_wb = 1'b0;
        step();
        chk("byp_nowr_ru1", ru1_ex, 32'hAAAA);
        RuWr_wb = 1'b1; rs2_de = 5'd6;
        step();
        chk("byp_only1_ru1", ru1_ex, 32'h1234);
        chk("byp_only1_ru2", ru2_ex, 32'hAAAA);

        clear_in();
        valid_de = 1'b0; RuWr = 1'b1; DMWr = 1'b1; BrOp = 5'h3;
        step();
        chk("inv_valid", valid_ex, 1'b0);
        chk("inv_ruwr", RuWr_ex, 1'b0);
        chk("inv_dmwr", DMWr_ex, 1'b0);
        chk("inv_brop", BrOp_ex, 5'd0);
        chk("inv_cnt", bubble_cnt, 2'd1);

        clear_in();
        valid_de = 1'b1; rs1_de = 5'd2; rs2_de = 5'd7; ru1 = 32'h55; ru2 = 32'h1;
        AluOp = 4'h9; pc_de = 32'h200;
        step();
        stall = 1'b1; ru2 = 32'hFFFF; pc_de = 32'h300; AluOp = 4'h1; rs2_de = 5'd9;
        step();
        chk("stall1_ru2", ru2_ex, 32'h1);
        chk("stall1_pc", pc_ex, 32'h200);
        RuWr_wb = 1'b1; rd_wb = 5'd7; muxData = 32'hBEEF;
        step();
        chk("stall2_ru2", ru2_ex, 32'hBEEF);
        chk("stall2_ru1", ru1_ex, 32'h55);
        chk("stall2_pc", pc_ex, 32'h200);
        chk("stall2_aluop", AluOp_ex, 4'h9);
        chk("stall2_rs2", rs2_ex, 5'd7);
        chk("stall2_valid", valid_ex, 1'b1);
        RuWr_wb = 1'b0;
        step();
        chk("stall3_ru2", ru2_ex, 32'hBEEF);
        RuWr_wb = 1'b1; rd_wb = 5'd2; muxData = 32'hCAFE;
        step();
        chk("stall4_ru1", ru1_ex, 32'hCAFE);
        chk("stall4_ru2", ru2_ex, 32'hBEEF);
        chk("stall4_cnt", bubble_cnt, 2'd1);

        clear_in();
        valid_de = 1'b1; RuWr = 1'b1; DMWr = 1'b1; BrOp = 5'h3; pc_de = 32'h400;
        step();
        chk("pre_flush_ruwr", RuWr_ex, 1'b1);
        chk("pre_flush_brop", BrOp_ex, 5'h3);
        stall = 1'b1; flush = 1'b1;
        step();
        chk("flush_valid", valid_ex, 1'b0);
        chk("flush_ruwr", RuWr_ex, 1'b0);
        chk("flush_dmwr", DMWr_ex, 1'b0);
        chk("flush_brop", BrOp_ex, 5'd0);
        chk("flush_pc", pc_ex, 32'd0);
        chk("flush_cnt", bubble_cnt, 2'd2);

        stall = 1'b0; flush = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; flush = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("sat_cnt%0d", i), bubble_cnt, (i < 3) ? 2'(i + 1) : 2'd3);
        end

        clear_in();
        valid_de = 1'b1; pc_de = 32'h500; ru1 = 32'h77; AluOp = 4'h5;
        step();
        chk("pre_rst_valid", valid_ex, 1'b1);
        stall = 1'b1; rst = 1'b1;
        step();
        chk("rst_stall_zero", all_zero(), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
